// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller and its datapath.
// Opcodes, funct codes, FSM states, mux-select encodings and the instruction class.
package multi_cycle_ctrl_pkg;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_HALT} state_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_REGIMM = 6'b000001,
                         OP_J       = 6'b000010, OP_JAL    = 6'b000011,
                         OP_BEQ     = 6'b000100, OP_ORI    = 6'b001101,
                         OP_LUI     = 6'b001111, OP_LB     = 6'b100000,
                         OP_LW      = 6'b100011, OP_SB     = 6'b101000,
                         OP_SW      = 6'b101011;
  localparam logic [5:0] FN_SLL = 6'b000000, FN_JR = 6'b001000,
                         FN_ADDU = 6'b100001, FN_SUBU = 6'b100011;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [1:0] NPC_PC4 = 2'b00, NPC_BR = 2'b01, NPC_J = 2'b10, NPC_JR = 2'b11;
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] MTR_ALU = 2'b00, MTR_DM = 2'b01, MTR_PC4 = 2'b10;
  localparam logic [1:0] EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_LUI = 2'b10;
  localparam logic [2:0] ALU_ADDU = 3'b000, ALU_SUBU = 3'b001, ALU_OR = 3'b010,
                         ALU_SLL = 3'b011, ALU_BGEZ = 3'b100;

  // Exactly one field is set for any instruction word.
  typedef struct packed {
    logic addu, subu, sll, jr, ori, lui, lw, sw, lb, sb, beq, j, jal, bgezal, illegal;
  } icls_t;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: master is the controller, slave the datapath.
interface multi_cycle_ctrl_if;
  logic [31:0] Instr;
  logic        Zero, Bgezal_op;
  logic [1:0]  Regdst, Memtoreg, Extop, Npc_sel;
  logic        Alusrc, Memwrite, Regwrite;
  logic [2:0]  Aluop;
  logic        If_lb, If_sb, PC_en, IR_en, Halt;

  modport master (input Instr, Zero, Bgezal_op,
                  output Regdst, Alusrc, Memtoreg, Memwrite, Regwrite, Extop,
                         Npc_sel, Aluop, If_lb, If_sb, PC_en, IR_en, Halt);
  modport slave  (output Instr, Zero, Bgezal_op,
                  input  Regdst, Alusrc, Memtoreg, Memwrite, Regwrite, Extop,
                         Npc_sel, Aluop, If_lb, If_sb, PC_en, IR_en, Halt);
endinterface

// File: rtl/multi_cycle_ctrl_instr_decode.sv
// Combinational instruction classifier: instruction word in, one-hot class out.
module instr_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output icls_t       cls
);
  logic unused_fields;
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  always_comb begin
    cls = '0;
    unique case (instr[31:26])
      OP_SPECIAL: begin
        case (instr[5:0])
          FN_ADDU: cls.addu    = 1'b1;
          FN_SUBU: cls.subu    = 1'b1;
          FN_SLL:  cls.sll     = 1'b1;
          FN_JR:   cls.jr      = 1'b1;
          default: cls.illegal = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        if (instr[20:16] == RT_BGEZAL) cls.bgezal  = 1'b1;
        else                           cls.illegal = 1'b1;
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_LB:   cls.lb      = 1'b1;
      OP_SB:   cls.sb      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle controller FSM (FETCH/DECODE/EXE/MEM/WB/HALT) for a MIPS subset.
// Define CTRL_ILLEGAL_HALT_EN to halt on unsupported instructions instead of treating them as nop.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  multi_cycle_ctrl_if.master bus
);
  icls_t  cls;
  state_e state_q, state_d;
  logic   is_r, is_ld, is_st;

  instr_decode u_dec (.instr(bus.Instr), .cls(cls));

  assign is_r  = cls.addu | cls.subu | cls.sll;
  assign is_ld = cls.lw | cls.lb;
  assign is_st = cls.sw | cls.sb;

`ifdef CTRL_ILLEGAL_HALT_EN
  logic halt_q, halt_d;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end
  assign bus.Halt = halt_q;
`else
  assign bus.Halt = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
`ifdef CTRL_ILLEGAL_HALT_EN
    halt_d       = halt_q;
`endif
    bus.Regdst   = RD_RT;
    bus.Alusrc   = 1'b0;
    bus.Memtoreg = MTR_ALU;
    bus.Memwrite = 1'b0;
    bus.Regwrite = 1'b0;
    bus.Extop    = EXT_ZERO;
    bus.Npc_sel  = NPC_PC4;
    bus.Aluop    = ALU_ADDU;
    bus.If_lb    = 1'b0;
    bus.If_sb    = 1'b0;
    bus.PC_en    = 1'b0;
    bus.IR_en    = 1'b0;

    // ALU-side selects are held for the whole instruction once IR is loaded.
    if (state_q inside {S_DECODE, S_EXE, S_MEM, S_WB}) begin
      bus.Alusrc = cls.ori | cls.lui | is_ld | is_st;
      if (cls.lui)                                   bus.Extop = EXT_LUI;
      else if (is_ld | is_st | cls.beq | cls.bgezal) bus.Extop = EXT_SIGN;
      if (cls.subu | cls.beq)      bus.Aluop = ALU_SUBU;
      else if (cls.ori | cls.lui)  bus.Aluop = ALU_OR;
      else if (cls.sll)            bus.Aluop = ALU_SLL;
      else if (cls.bgezal)         bus.Aluop = ALU_BGEZ;
    end

    case (state_q)
      S_FETCH: begin
        bus.IR_en = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        if (cls.j | cls.jal | cls.jr) begin
          bus.PC_en   = 1'b1;
          bus.Npc_sel = cls.jr ? NPC_JR : NPC_J;
          if (cls.jal) begin
            bus.Regwrite = 1'b1;
            bus.Regdst   = RD_RA;
            bus.Memtoreg = MTR_PC4;
          end
          state_d = S_FETCH;
        end else if (cls.illegal) begin
`ifdef CTRL_ILLEGAL_HALT_EN
          halt_d    = 1'b1;
          state_d   = S_HALT;
`else
          bus.PC_en = 1'b1;
          state_d   = S_FETCH;
`endif
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (cls.beq) begin
          bus.PC_en   = 1'b1;
          bus.Npc_sel = bus.Zero ? NPC_BR : NPC_PC4;
          state_d     = S_FETCH;
        end else if (cls.bgezal) begin
          bus.PC_en = 1'b1;
          if (bus.Bgezal_op) begin
            bus.Npc_sel  = NPC_BR;
            bus.Regwrite = 1'b1;
            bus.Regdst   = RD_RA;
            bus.Memtoreg = MTR_PC4;
          end
          state_d = S_FETCH;
        end else if (is_ld | is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_st) begin
          bus.Memwrite = 1'b1;
          bus.If_sb    = cls.sb;
          bus.PC_en    = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        bus.Regwrite = 1'b1;
        bus.PC_en    = 1'b1;
        bus.Regdst   = is_r ? RD_RD : RD_RT;
        bus.Memtoreg = is_ld ? MTR_DM : MTR_ALU;
        bus.If_lb    = cls.lb;
        state_d      = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Reset kills strobes combinationally so no write slips out mid-instruction.
    if (!RESET) begin
      bus.PC_en    = 1'b0;
      bus.IR_en    = 1'b0;
      bus.Regwrite = 1'b0;
      bus.Memwrite = 1'b0;
    end
  end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle checks of every control output.
module tb_multi_cycle_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  int   n_chk = 0;
  int   n_fail = 0;

  multi_cycle_ctrl_if bus ();
  multi_cycle_ctrl dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  localparam logic L = 1'b0, H = 1'b1;
  localparam logic [31:0] ADDU = 32'h0022_1821, SUBU = 32'h0022_1823, SLL = 32'h0002_5100,
                          LW = 32'h8C25_0004, LB = 32'h8029_0000, SW = 32'hAC26_0008,
                          SB = 32'hA029_0000, BEQ = 32'h1022_0003, JAL = 32'h0C00_0010,
                          JR = 32'h03E0_0008, BGEZAL = 32'h0431_0002, ORI = 32'h3427_00FF,
                          LUI = 32'h3C08_1234, ILL = 32'hFC00_0000;

  logic [18:0] ctl;
  assign ctl = {bus.Regdst, bus.Alusrc, bus.Memtoreg, bus.Memwrite, bus.Regwrite, bus.Extop,
                bus.Npc_sel, bus.Aluop, bus.If_lb, bus.If_sb, bus.PC_en, bus.IR_en, bus.Halt};

  function automatic logic [18:0] v(logic [1:0] rd, logic as, logic [1:0] mtr, logic mw,
                                    logic rw, logic [1:0] ext, logic [1:0] npc, logic [2:0] alu,
                                    logic lb, logic sb, logic pc, logic ir, logic h);
    return {rd, as, mtr, mw, rw, ext, npc, alu, lb, sb, pc, ir, h};
  endfunction

  localparam logic [18:0] Z  = 19'd0;
  localparam logic [18:0] FE = 19'b00_0_00_0_0_00_00_000_0_0_0_1_0;

  task automatic chk(input string tag, input logic [18:0] exp);
    n_chk++;
    assert (ctl === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, ctl, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; bus.Instr = ADDU; bus.Zero = 1'b0; bus.Bgezal_op = 1'b0;
    repeat (2) @(negedge CLK);
    #1 chk("reset", Z);
    @(negedge CLK); RESET = 1'b1;
    #1 chk("addu c0", FE);
    cyc(); chk("addu c1", Z);
    cyc(); chk("addu c2", Z);
    cyc(); chk("addu c3", v(2'b01, L, 2'b00, L, H, 2'b00, 2'b00, 3'b000, L, L, H, L, L));
    cyc(); chk("lw c0", FE); bus.Instr = LW;
    cyc(); chk("lw c1", v(2'b00, H, 2'b00, L, L, 2'b01, 2'b00, 3'b000, L, L, L, L, L));
    cyc(); chk("lw c2", v(2'b00, H, 2'b00, L, L, 2'b01, 2'b00, 3'b000, L, L, L, L, L));
    cyc(); chk("lw c3", v(2'b00, H, 2'b00, L, L, 2'b01, 2'b00, 3'b000, L, L, L, L, L));
    cyc(); chk("lw c4", v(2'b00, H, 2'b01, L, H, 2'b01, 2'b00, 3'b000, L, L, H, L, L));
    cyc(); chk("beq1 c0", FE); bus.Instr = BEQ; bus.Zero = 1'b1;
    cyc(); chk("beq1 c1", v(2'b00, L, 2'b00, L, L, 2'b01, 2'b00, 3'b001, L, L, L, L, L));
    cyc(); chk("beq1 c2", v(2'b00, L, 2'b00, L, L, 2'b01, 2'b01, 3'b001, L, L, H, L, L));
    cyc(); chk("beq0 c0", FE); bus.Zero = 1'b0;
    cyc(); chk("beq0 c1", v(2'b00, L, 2'b00, L, L, 2'b01, 2'b00, 3'b001, L, L, L, L, L));
    cyc(); chk("beq0 c2", v(2'b00, L, 2'b00, L, L, 2'b01, 2'b00, 3'b001, L, L, H, L, L));
    cyc(); chk("jal c0", FE); bus.Instr = JAL;
    cyc(); chk("jal c1", v(2'b10, L, 2'b10, L, H, 2'b00, 2'b10, 3'b000, L, L, H, L, L));
    cyc(); chk("jr c0", FE); bus.Instr = JR;
    cyc(); chk("jr c1", v(2'b00, L, 2'b00, L, L, 2'b00, 2'b11, 3'b000, L, L, H, L, L));
    cyc(); chk("bgez1 c0", FE); bus.Instr = BGEZAL; bus.Bgezal_op = 1'b1;
    cyc(); chk("bgez1 c1", v(2'b00, L, 2'b00, L, L, 2'b01, 2'b00, 3'b100, L, L, L, L, L));
    cyc(); chk("bgez1 c2", v(2'b10, L, 2'b10, L, H, 2'b01, 2'b01, 3'b100, L, L, H, L, L));
    cyc(); chk("bgez0 c0", FE); bus.Bgezal_op = 1'b0;
    cyc(); chk("bgez0 c1", v(2'b00, L, 2'b00, L, L, 2'b01, 2'b00, 3'b100, L, L, L, L, L));
    cyc(); chk("bgez0 c2", v(2'b00, L, 2'b00, L, L, 2'b01, 2'b00, 3'b100, L, L, H, L, L));
    cyc(); chk("ori c0", FE); bus.Instr = ORI;
    cyc(); chk("ori c1", v(2'b00, H, 2'b00, L, L, 2'b00, 2'b00, 3'b010, L, L, L, L, L));
    cyc(); chk("ori c2", v(2'b00, H, 2'b00, L, L, 2'b00, 2'b00, 3'b010, L, L, L, L, L));
    cyc(); chk("ori c3", v(2'b00, H, 2'b00, L, H, 2'b00, 2'b00, 3'b010, L, L, H, L, L));
    cyc(); chk("lui c0", FE); bus.Instr = LUI;
    cyc(); chk("lui c1", v(2'b00, H, 2'b00, L, L, 2'b10, 2'b00, 3'b010, L, L, L, L, L));
    cyc();
    cyc(); chk("lui c3", v(2'b00, H, 2'b00, L, H, 2'b10, 2'b00, 3'b010, L, L, H, L, L));
    cyc(); chk("lb c0", FE); bus.Instr = LB;
    repeat (3) cyc();
    chk("lb c3", v(2'b00, H, 2'b00, L, L, 2'b01, 2'b00, 3'b000, L, L, L, L, L));
    cyc(); chk("lb c4", v(2'b00, H, 2'b01, L, H, 2'b01, 2'b00, 3'b000, H, L, H, L, L));
    cyc(); chk("sb c0", FE); bus.Instr = SB;
    repeat (2) cyc();
    chk("sb c2", v(2'b00, H, 2'b00, L, L, 2'b01, 2'b00, 3'b000, L, L, L, L, L));
    cyc(); chk("sb c3", v(2'b00, H, 2'b00, H, L, 2'b01, 2'b00, 3'b000, L, H, H, L, L));
    cyc(); chk("sll c0", FE); bus.Instr = SLL;
    repeat (3) cyc();
    chk("sll c3", v(2'b01, L, 2'b00, L, H, 2'b00, 2'b00, 3'b011, L, L, H, L, L));
    cyc(); chk("subu c0", FE); bus.Instr = SUBU;
    repeat (3) cyc();
    chk("subu c3", v(2'b01, L, 2'b00, L, H, 2'b00, 2'b00, 3'b001, L, L, H, L, L));
    cyc(); chk("sw c0", FE); bus.Instr = SW;
    repeat (3) cyc();
    chk("sw c3", v(2'b00, H, 2'b00, H, L, 2'b01, 2'b00, 3'b000, L, L, H, L, L));
    #2 RESET = 1'b0;
    #1 chk("sw mid reset", Z);
    @(negedge CLK); RESET = 1'b1;
    #1 chk("post reset c0", FE); bus.Instr = ILL;
`ifdef CTRL_ILLEGAL_HALT_EN
    cyc(); chk("ill c1", Z);
    cyc(); chk("ill halt", 19'd1);
    cyc(); chk("ill halt hold", 19'd1);
    RESET = 1'b0;
    #1 chk("halt reset", Z);
    @(negedge CLK); RESET = 1'b1;
`else
    cyc(); chk("ill c1", v(2'b00, L, 2'b00, L, L, 2'b00, 2'b00, 3'b000, L, L, H, L, L));
    cyc(); chk("ill c2 fetch", FE);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Ports SHALL be, one per line as name, direction, width, meaning:
- CLK  in  1  single clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Instr  in  32  instruction word from the datapath, held stable by the datapath IR while IR_en is low.
- Zero  in  1  ALU equality flag.
- Bgezal_op  in  1  ALU flag, high when rs is greater than or equal to 0.
- Regdst  out  2  00 rt, 01 rd, 10 $31.
- Alusrc  out  1  0 rt data, 1 extended immediate.
- Memtoreg  out  2  00 ALU, 01 DM, 10 PC+4.
- Memwrite  out  1  DM write strobe.
- Regwrite  out  1  GRF write strobe.
- Extop  out  2  00 zero-extend, 01 sign-extend, 10 load-upper.
- Npc_sel  out  2  00 PC+4, 01 branch, 10 j/jal, 11 jr.
- Aluop  out  3  000 addu, 001 subu, 010 or, 011 sll, 100 bgezal compare.
- If_lb  out  1  byte-load select.
- If_sb  out  1  byte-store select.
- PC_en  out  1  PC load enable.
- IR_en  out  1  IR load enable.
- Halt  out  1  sticky halt flag.

Function
REQ-002 The FSM SHALL have six states: FETCH, DECODE, EXE, MEM, WB, HALT.
REQ-003 Outputs SHALL be Moore-decoded from the state register and Instr[31:26]/[5:0]. Every enable SHALL be low outside the state named for it.
REQ-004 FETCH SHALL assert IR_en for exactly one cycle, then go to DECODE.
REQ-005 Supported instructions: addu, subu, sll, jr (SPECIAL funct), ori, lui, lw, sw, lb, sb, beq, j, jal, bgezal (REGIMM rt=10001).
REQ-006 DECODE transitions:
- j/jal/jr retire in DECODE: PC_en=1 with Npc_sel 10/10/11.
- jal additionally SHALL assert Regwrite=1, Regdst=10, Memtoreg=10.
- All other supported instructions go to EXE.
REQ-007 EXE for R-type, ori and lui SHALL go to WB.
REQ-008 WB SHALL assert Regwrite=1, then go to FETCH.
REQ-009 EXE for beq SHALL sample Zero, assert PC_en=1, and drive Npc_sel=01 if Zero=1, else 00.
REQ-010 EXE for bgezal SHALL sample Bgezal_op and assert PC_en=1.
- If Bgezal_op=1: Npc_sel=01, Regwrite=1, Regdst=10, Memtoreg=10.
- Otherwise: Npc_sel=00 and Regwrite=0.
- Then go to FETCH.
REQ-011 EXE for lw/lb/sw/sb SHALL drive Alusrc=1, Extop=01, Aluop=000, then go to MEM.
REQ-012 MEM for sw/sb SHALL assert Memwrite=1 (If_sb=1 for sb) and PC_en=1 with Npc_sel=00, then go to FETCH.
REQ-013 MEM for lw/lb SHALL go to WB.
REQ-014 WB for lw/lb SHALL drive Memtoreg=01 (If_lb=1 for lb) and Regwrite=1. For other instructions, WB SHALL drive Memtoreg=00.
REQ-015 Every instruction retiring from WB SHALL assert PC_en=1 with Npc_sel=00 in WB.
REQ-016 PC_en SHALL pulse exactly once per instruction. Cycle counts:
- j/jal/jr: 2 cycles.
- beq/bgezal: 3 cycles.
- sw/sb and ALU ops: 4 cycles.
- lw/lb: 5 cycles.
REQ-017 Regdst SHALL be 01 for R-type and 00 for I-type writes.
REQ-018 Extop SHALL be 00 for ori, 10 for lui, and 01 for loads, stores and branches.
REQ-019 sll SHALL drive Aluop=011, with shamt taken from Instr[10:6] by the datapath.
REQ-020 Unsupported opcodes SHALL be handled per REQ-024.
REQ-021 In HALT all enables SHALL be 0 and the state SHALL remain HALT until reset.

Reset
REQ-022 RESET low SHALL asynchronously force state FETCH, Halt=0, and all enables 0, including when asserted mid-instruction. No partial write may occur after reset assertion.
REQ-023 After RESET deasserts, the first rising edge SHALL begin a FETCH cycle.

Configuration
REQ-024 Macro CTRL_ILLEGAL_HALT_EN SHALL control unsupported-opcode handling:
- Defined: an unsupported opcode/funct in DECODE goes to HALT and sets Halt=1.
- Undefined: it is treated as nop (PC_en=1, Npc_sel=00 in DECODE, back to FETCH), and Halt is tied 0.

Structure
REQ-025 Opcode/funct constants, the state encoding, and the Npc_sel/Regdst/Memtoreg/Extop/Aluop encodings SHALL live in a shared package used by both the datapath and this block.
REQ-026 One sub-module, instr_decode, SHALL be combinational: Instr in, one-hot instruction class out. It is used by the FSM.

Verification
REQ-027 addu $3,$1,$2 -> IR_en at cycle 0; Regwrite=1, Regdst=01, PC_en=1 at cycle 3; nothing else asserted.
REQ-028 lw (opcode 100011) -> 5 cycles; Memtoreg=01 and Regwrite=1 only in WB; Memwrite never 1.
REQ-029 beq with Zero=1, then with Zero=0 -> PC_en in cycle 2 with Npc_sel 01, then 00; Regwrite=0.
REQ-030 jal -> 2 cycles; DECODE drives Regdst=10, Memtoreg=10, Regwrite=1, Npc_sel=10.
REQ-031 RESET low during MEM of sw -> Memwrite drops to 0 immediately; FETCH is the first state after release.
REQ-032 Opcode 111111 -> with CTRL_ILLEGAL_HALT_EN: Halt=1 and no enables thereafter. Without it: PC_en=1 and return to FETCH.
